// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard/forwarding controller for the 5-stage F/D/E/M/W pipeline.
// Produces per-stage stall/flush enables, D/E forwarding selects and sequences a
// multi-cycle divider. It also holds E while a load waits for data_ok_m, and it
// keeps an exception flush pending until that memory wait resolves.
// Optional feature: define HAZARD_PERF_EN to build the stall_cyc/div_cyc counters.
// Without that define, the counter outputs are tied to 0.
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              branch_d,
  input  logic              jr_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] wreg_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [1:0]        hilo_rd_e,
  input  logic              div_start_e,
  input  logic [REG_AW-1:0] wreg_m,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic              hilo_wr_m,
  input  logic              data_ok_m,
  input  logic [REG_AW-1:0] wreg_w,
  input  logic              regwrite_w,
  input  logic              hilo_wr_w,
  input  logic              excp_m,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [1:0]        fwd_hilo_e,
  output logic              div_busy,
  output logic              div_done,
  output logic [CNT_W-1:0]  stall_cyc,
  output logic [CNT_W-1:0]  div_cyc
);

  localparam int DCW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divState_t;

  divState_t      divState;
  logic [DCW-1:0] divCnt;
  logic           divBusy;
  logic           divDone;
  logic           flushPend;

  logic memWait, flushNow;
  logic luStall, brHitE, brHitM, divStall, dStall;
  logic rsIsBrSrc;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic regMatch(input logic [REG_AW-1:0] src,
                                    input logic [REG_AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  assign memWait   = memtoreg_m & ~data_ok_m;
  // An exception fires immediately, or it fires when the memory wait that delayed it ends.
  assign flushNow  = ~memWait & (excp_m | flushPend);

  assign luStall   = memtoreg_e & ((use_rs_d & regMatch(rs_d, wreg_e)) |
                                   (use_rt_d & regMatch(rt_d, wreg_e)));
  // Both branch types compare rs. Only compare-branches also compare rt.
  assign rsIsBrSrc = branch_d | jr_d;
  assign brHitE    = regwrite_e & ((rsIsBrSrc & regMatch(rs_d, wreg_e)) |
                                   (branch_d  & regMatch(rt_d, wreg_e)));
  assign brHitM    = memtoreg_m & ((rsIsBrSrc & regMatch(rs_d, wreg_m)) |
                                   (branch_d  & regMatch(rt_d, wreg_m)));

  // Lower-priority stall sources are masked by every higher-priority condition.
  assign divStall  = divBusy & ~memWait & ~flushNow;
  assign dStall    = (luStall | brHitE | brHitM) & ~memWait & ~flushNow & ~divBusy;

  assign stall_f   = memWait | divStall | dStall;
  assign stall_d   = memWait | divStall | dStall;
  assign stall_e   = memWait | divStall;
  assign stall_m   = memWait;
  assign flush_d   = flushNow;
  assign flush_e   = flushNow | dStall;
  assign flush_m   = flushNow | divStall;
  assign flush_w   = memWait;

  assign fwd_a_d   = regMatch(rs_d, wreg_m) & regwrite_m & ~memtoreg_m;
  assign fwd_b_d   = regMatch(rt_d, wreg_m) & regwrite_m & ~memtoreg_m;

  assign div_busy  = divBusy;
  assign div_done  = divDone;

  // E-stage operand and HI/LO forwarding selects: the M stage has priority over W.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
    fwd_a_e    = 2'b00;
    fwd_b_e    = 2'b00;
    fwd_hilo_e = 2'b00;
    if (regMatch(rs_e, wreg_m) && regwrite_m && !memtoreg_m) fwd_a_e = 2'b10;
    else if (regMatch(rs_e, wreg_w) && regwrite_w)           fwd_a_e = 2'b01;
    if (regMatch(rt_e, wreg_m) && regwrite_m && !memtoreg_m) fwd_b_e = 2'b10;
    else if (regMatch(rt_e, wreg_w) && regwrite_w)           fwd_b_e = 2'b01;
    if ((hilo_rd_e != 2'b00) && hilo_wr_m) fwd_hilo_e = 2'b01;
    else if (hilo_wr_w)                    fwd_hilo_e = 2'b10;
  end

  // Divider sequencer: IDLE -> BUSY for DIV_CYCLES-1 cycles -> DONE for one cycle -> IDLE.
  // The busy/done flags are registered alongside the state.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (!resetn) begin
      divState <= DIV_IDLE;
      divCnt   <= '0;
      divBusy  <= 1'b0;
      divDone  <= 1'b0;
    end else if (flushNow) begin
      divState <= DIV_IDLE;
      divCnt   <= '0;
      divBusy  <= 1'b0;
      divDone  <= 1'b0;
    end else begin
      case (divState)
        DIV_IDLE: begin
          if (div_start_e) begin
            divState <= DIV_BUSY;
            divCnt   <= DCW'(DIV_CYCLES - 1);
            divBusy  <= 1'b1;
          end
        end
        DIV_BUSY: begin
          if (divCnt == DCW'(1)) begin
            divState <= DIV_DONE;
            divBusy  <= 1'b0;
            divDone  <= 1'b1;
          end else begin
            divCnt <= divCnt - DCW'(1);
          end
        end
        DIV_DONE: begin
          // A div_start_e seen here comes from the same instruction, so it is ignored.
          divState <= DIV_IDLE;
          divDone  <= 1'b0;
        end
        default: begin
          divState <= DIV_IDLE;
          divBusy  <= 1'b0;
          divDone  <= 1'b0;
        end
      endcase
    end
  end

  // An exception taken during a memory wait is remembered until the wait ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) flushPend <= 1'b0;
    else         flushPend <= memWait & (excp_m | flushPend);
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallCyc;
  logic [CNT_W-1:0] divCyc;

  // Performance counters: these wrap naturally and hold during an exception flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stallCyc <= '0;
      divCyc   <= '0;
    end else begin
      if (stall_f && !flushNow) stallCyc <= stallCyc + CNT_W'(1);
      if (divBusy && !flushNow) divCyc   <= divCyc + CNT_W'(1);
    end
  end

  assign stall_cyc = stallCyc;
  assign div_cyc   = divCyc;
`else
  assign stall_cyc = '0;
  assign div_cyc   = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed scenarios and randomized stimulus for hazard_unit_mc.
// All outputs are checked against a priority-based behavioural model on every cycle.
module tb_hazard_unit_mc;
  localparam int REG_AW     = 5;
  localparam int DIV_CYCLES = 33;
  localparam int CNT_W      = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic use_rs_d, use_rt_d, branch_d, jr_d, regwrite_e, memtoreg_e, div_start_e;
  logic regwrite_m, memtoreg_m, hilo_wr_m, data_ok_m, regwrite_w, hilo_wr_w, excp_m;
  logic [1:0] hilo_rd_e;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
  logic fwd_a_d, fwd_b_d, div_busy, div_done;
  logic [1:0] fwd_a_e, fwd_b_e, fwd_hilo_e;
  logic [CNT_W-1:0] stall_cyc, div_cyc;

  hazard_unit_mc #(.REG_AW(REG_AW), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .branch_d(branch_d), .jr_d(jr_d),
    .rs_e(rs_e), .rt_e(rt_e), .wreg_e(wreg_e), .regwrite_e(regwrite_e),
    .memtoreg_e(memtoreg_e), .hilo_rd_e(hilo_rd_e), .div_start_e(div_start_e),
    .wreg_m(wreg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .hilo_wr_m(hilo_wr_m), .data_ok_m(data_ok_m),
    .wreg_w(wreg_w), .regwrite_w(regwrite_w), .hilo_wr_w(hilo_wr_w), .excp_m(excp_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .fwd_hilo_e(fwd_hilo_e), .div_busy(div_busy), .div_done(div_done),
    .stall_cyc(stall_cyc), .div_cyc(div_cyc)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state. divLeft counts the cycles left in a divide, including the done cycle.
  // A value of 0 means no divide is in progress.
  int               divLeft = 0;
  bit               pend = 1'b0;
  logic [CNT_W-1:0] mStallCyc = '0;
  logic [CNT_W-1:0] mDivCyc = '0;

  function automatic bit dep(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return (src != 0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwdE(input logic [REG_AW-1:0] src);
    if (dep(src, wreg_m) && regwrite_m && !memtoreg_m) return 2'b10;
    if (dep(src, wreg_w) && regwrite_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit brNeeds(input logic [REG_AW-1:0] w);
    return ((branch_d || jr_d) && dep(rs_d, w)) || (branch_d && dep(rt_d, w));
  endfunction

  // Check all outputs against the model, then advance the model across the coming rising edge.
  task automatic checkAndStep(input string tag);
    bit mw, fl, busy, done, lu, br;
    bit sf, sd, se, sm, fd, fe, fm, fw;
    logic [1:0] hl;
    mw = memtoreg_m && !data_ok_m;
    fl = !mw && (excp_m || pend);
    busy = divLeft > 1;
    done = divLeft == 1;
    lu = memtoreg_e && ((use_rs_d && dep(rs_d, wreg_e)) || (use_rt_d && dep(rt_d, wreg_e)));
    br = (regwrite_e && brNeeds(wreg_e)) || (memtoreg_m && brNeeds(wreg_m));
    {sf, sd, se, sm, fd, fe, fm, fw} = '0;
    if (mw)             begin sf = 1; sd = 1; se = 1; sm = 1; fw = 1; end
    else if (fl)        begin fd = 1; fe = 1; fm = 1; end
    else if (busy)      begin sf = 1; sd = 1; se = 1; fm = 1; end
    else if (lu || br)  begin sf = 1; sd = 1; fe = 1; end
    hl = 2'b00;
    if (hilo_rd_e != 0 && hilo_wr_m) hl = 2'b01;
    else if (hilo_wr_w)              hl = 2'b10;

    check({tag, ".stall_f"}, stall_f, sf);
    check({tag, ".stall_d"}, stall_d, sd);
    check({tag, ".stall_e"}, stall_e, se);
    check({tag, ".stall_m"}, stall_m, sm);
    check({tag, ".flush_d"}, flush_d, fd);
    check({tag, ".flush_e"}, flush_e, fe);
    check({tag, ".flush_m"}, flush_m, fm);
    check({tag, ".flush_w"}, flush_w, fw);
    check({tag, ".fwd_a_d"}, fwd_a_d, dep(rs_d, wreg_m) && regwrite_m && !memtoreg_m);
    check({tag, ".fwd_b_d"}, fwd_b_d, dep(rt_d, wreg_m) && regwrite_m && !memtoreg_m);
    check({tag, ".fwd_a_e"}, fwd_a_e, fwdE(rs_e));
    check({tag, ".fwd_b_e"}, fwd_b_e, fwdE(rt_e));
    check({tag, ".fwd_hilo_e"}, fwd_hilo_e, hl);
    check({tag, ".div_busy"}, div_busy, busy);
    check({tag, ".div_done"}, div_done, done);
`ifdef HAZARD_PERF_EN
    check({tag, ".stall_cyc"}, stall_cyc, mStallCyc);
    check({tag, ".div_cyc"}, div_cyc, mDivCyc);
`else
    check({tag, ".stall_cyc"}, stall_cyc, 0);
    check({tag, ".div_cyc"}, div_cyc, 0);
`endif

    if (sf && !fl)   mStallCyc = mStallCyc + 1;
    if (busy && !fl) mDivCyc = mDivCyc + 1;
    pend = mw && (excp_m || pend);
    if (fl)               divLeft = 0;
    else if (divLeft > 0) divLeft = divLeft - 1;
    else if (div_start_e) divLeft = DIV_CYCLES;
  endtask

  // Called at a falling edge with the inputs already driven. It checks mid-cycle and returns at the next falling edge.
  task automatic runCycle(input string tag);
    #2;
    checkAndStep(tag);
    @(negedge clk);
  endtask

  task automatic setIdle();
    rs_d = 0; rt_d = 0; use_rs_d = 0; use_rt_d = 0; branch_d = 0; jr_d = 0;
    rs_e = 0; rt_e = 0; wreg_e = 0; regwrite_e = 0; memtoreg_e = 0;
    hilo_rd_e = 0; div_start_e = 0;
    wreg_m = 0; regwrite_m = 0; memtoreg_m = 0; hilo_wr_m = 0; data_ok_m = 1;
    wreg_w = 0; regwrite_w = 0; hilo_wr_w = 0; excp_m = 0;
  endtask

  task automatic setRandom();
    rs_d = REG_AW'($urandom_range(0, 3)); rt_d = REG_AW'($urandom_range(0, 3));
    use_rs_d = 1'($urandom); use_rt_d = 1'($urandom);
    branch_d = ($urandom_range(0, 3) == 0); jr_d = ($urandom_range(0, 7) == 0);
    rs_e = REG_AW'($urandom_range(0, 3)); rt_e = REG_AW'($urandom_range(0, 3));
    wreg_e = REG_AW'($urandom_range(0, 3));
    regwrite_e = 1'($urandom); memtoreg_e = ($urandom_range(0, 3) == 0);
    hilo_rd_e = 2'($urandom); div_start_e = ($urandom_range(0, 29) == 0);
    wreg_m = REG_AW'($urandom_range(0, 3)); regwrite_m = 1'($urandom);
    memtoreg_m = ($urandom_range(0, 3) == 0); hilo_wr_m = ($urandom_range(0, 3) == 0);
    data_ok_m = ($urandom_range(0, 2) != 0);
    wreg_w = REG_AW'($urandom_range(0, 3)); regwrite_w = 1'($urandom);
    hilo_wr_w = ($urandom_range(0, 3) == 0); excp_m = ($urandom_range(0, 24) == 0);
  endtask

  // Asserts reset between clock edges, checks that the outputs clear before the next edge, then releases reset.
  task automatic asyncReset(input string tag);
    #2;
    resetn = 0;
    #1;
    divLeft = 0; pend = 0; mStallCyc = '0; mDivCyc = '0;
    check({tag, ".div_busy"}, div_busy, 0);
    check({tag, ".stall_e"}, stall_e, 0);
    check({tag, ".flush_m"}, flush_m, 0);
    @(negedge clk);
    resetn = 1;
  endtask

  int busyCnt, doneCnt, doneAt;

  initial begin
    setIdle();
    @(negedge clk);
    #2;
    check("reset.stall_f", stall_f, 0);
    check("reset.div_busy", div_busy, 0);
    check("reset.flush_e", flush_e, 0);
    check("reset.fwd_a_e", fwd_a_e, 0);
    check("reset.stall_cyc", stall_cyc, 0);
    @(negedge clk);
    resetn = 1;
    runCycle("idle");

    // Scenario 1: forward from M, then from W once the producer has moved to W.
    setIdle(); wreg_m = 3; regwrite_m = 1; rs_e = 3; rt_e = 0;
    #1; check("t1.fwd_m", fwd_a_e, 2'b10); check("t1.fwd_b_r0", fwd_b_e, 2'b00);
    runCycle("t1a");
    setIdle(); wreg_m = 7; regwrite_m = 1; wreg_w = 3; regwrite_w = 1; rs_e = 3;
    #1; check("t1.fwd_w", fwd_a_e, 2'b01);
    runCycle("t1b");
    setIdle(); hilo_rd_e = 2'b10; hilo_wr_m = 1; hilo_wr_w = 1;
    #1; check("t1.hilo_m", fwd_hilo_e, 2'b01);
    runCycle("t1c");

    // Scenario 2: load-use stall, then a branch stall against the load while it is in M.
    setIdle(); memtoreg_e = 1; regwrite_e = 1; wreg_e = 5;
    branch_d = 1; rs_d = 5; rt_d = 0; use_rs_d = 1; use_rt_d = 1;
    #1; check("t2.lu_stall_d", stall_d, 1); check("t2.lu_flush_e", flush_e, 1);
    runCycle("t2a");
    memtoreg_e = 0; regwrite_e = 0; wreg_e = 0; memtoreg_m = 1; regwrite_m = 1; wreg_m = 5;
    #1; check("t2.br_stall_f", stall_f, 1); check("t2.br_flush_e", flush_e, 1);
    runCycle("t2b");
    memtoreg_m = 0; regwrite_m = 0; wreg_m = 0; wreg_w = 5; regwrite_w = 1;
    #1; check("t2.released", stall_d, 0);
    runCycle("t2c");

    // Scenario 3: a full divide.
    setIdle(); div_start_e = 1;
    runCycle("t3start");
    div_start_e = 0;
    busyCnt = 0; doneCnt = 0; doneAt = 0;
    for (int i = 1; i <= DIV_CYCLES + 2; i++) begin
      #1;
      if (div_busy) busyCnt++;
      if (div_busy && !stall_e) check("t3.stall_e_busy", stall_e, 1);
      if (div_done) begin doneCnt++; doneAt = i; end
      runCycle("t3");
    end
    check("t3.busy_cycles", busyCnt, DIV_CYCLES - 1);
    check("t3.done_pulses", doneCnt, 1);
    check("t3.done_at", doneAt, DIV_CYCLES);

    // Scenarios 4 and 5: a four-cycle memory wait, with an exception in wait cycle 2 that is held pending.
    setIdle(); memtoreg_m = 1; regwrite_m = 1; wreg_m = 5; data_ok_m = 0;
    for (int i = 1; i <= 4; i++) begin
      excp_m = (i == 2);
      #1;
      check("t4.stall_m", stall_m, 1); check("t4.flush_w", flush_w, 1);
      check("t5.no_flush_d", flush_d, 0);
      runCycle("t4");
    end
    excp_m = 0; data_ok_m = 1;
    #1; check("t5.flush_d", flush_d, 1); check("t5.flush_m", flush_m, 1);
    check("t4.stall_f_rel", stall_f, 0);
    runCycle("t5a");
    setIdle();
    #1; check("t5.pend_clear", flush_d, 0);
    runCycle("t5b");

    // Scenario 6: an exception at busy cycle 10 aborts the divide. Then reset is asserted while a new divide is busy.
    setIdle(); div_start_e = 1;
    runCycle("t6start");
    div_start_e = 0;
    for (int i = 1; i < 10; i++) runCycle("t6busy");
    excp_m = 1;
    #1; check("t6.flush_e", flush_e, 1); check("t6.stall_e", stall_e, 0);
    runCycle("t6excp");
    excp_m = 0;
    #1; check("t6.busy_off", div_busy, 0);
    runCycle("t6after");
    div_start_e = 1;
    runCycle("t6restart");
    div_start_e = 0;
    for (int i = 0; i < 5; i++) runCycle("t6busy2");
    asyncReset("t6rst");

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        setIdle();
        asyncReset("rnd_rst");
      end
      setRandom();
      runCycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
